reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 16: width of each register and data port, in bits.
REQ-002 Parameter ADDR_W, default 4: width of each register select; register count is 2**ADDR_W (16 at default).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port wen, input, 1 bit: write enable for the write port.
REQ-006 Port selRd, input, ADDR_W bits: write-port register select.
REQ-007 Port selRa, input, ADDR_W bits: read-port A register select.
REQ-008 Port selRb, input, ADDR_W bits: read-port B register select.
REQ-009 Port rd, input, DATA_W bits: write data.
REQ-010 Port ra, output, DATA_W bits: read data A.
REQ-011 Port rb, output, DATA_W bits: read data B.
REQ-012 The block SHALL have one clock; reset SHALL be synchronous and active-high, named clk and rst.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits, indexed 0..2**ADDR_W-1.
REQ-014 All registers, including register 0, SHALL be ordinary read/write registers (no hardwired zero).
REQ-015 Write: at each rising clk with rst=0 and wen=1, register[selRd] SHALL load rd; all other registers hold.
REQ-016 With wen=0, no register SHALL change at the clock edge.
REQ-017 Reads SHALL be combinational: ra = register[selRa], rb = register[selRb], zero-cycle latency from select change.
REQ-018 Data written at edge N SHALL appear on ra/rb (when selected) immediately after edge N; before edge N the old value shows (no write-through bypass).
REQ-019 selRa and selRb MAY be equal; both outputs SHALL then show the same register.
REQ-020 Read select equal to selRd during a write SHALL show the old value until the edge, the new value after.
REQ-021 Write data SHALL be stored unmodified, full DATA_W width; no sign or zero manipulation.
REQ-022 X/Z-free: outputs SHALL be fully defined after the first reset edge.

Reset
REQ-023 At a rising clk with rst=1, every register SHALL clear to 0, regardless of wen, selRd, rd.
REQ-024 rst SHALL take priority over wen at the same edge; no write occurs during a reset cycle.
REQ-025 Assertion of rst without a clock edge SHALL NOT change contents (synchronous only).
REQ-026 After reset, ra and rb SHALL read 0 for every select value until written.
REQ-027 Before the first reset edge, register contents are unspecified.

Verification
REQ-028 rst=1, wen=1, rd=0xFFFF for 2 edges, then rst=0 -> ra=rb=0 for all selects 0..15 (reset beats write).
REQ-029 Sweep i=0..15: rd=i, selRd=selRa=selRb=i, wen=1, one edge each -> after each edge ra=rb=i; after sweep reading register k gives k.
REQ-030 wen=0, selRd=5, rd=0xBEEF, edge -> register 5 unchanged (still 5 after sweep).
REQ-031 selRa=3, selRb=12 simultaneously -> ra=3, rb=12; selRa=selRb=7 -> ra=rb=7.
REQ-032 selRd=selRa=9, rd=0x1234, wen=1: before edge ra=old value (9), after edge ra=0x1234 (no bypass).
REQ-033 Write 0xA5A5 to register 15, then rst=1 one edge -> all registers read 0, including 15.

Source files
------------

// File: rtl/reg_file_if.sv
// Register-file access bus: one write port and two read ports.
interface reg_file_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);

  logic              wen;
  logic [ADDR_W-1:0] selRd;
  logic [ADDR_W-1:0] selRa;
  logic [ADDR_W-1:0] selRb;
  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;

  // Requester side: drives the write port and both read selects.
  modport master (
    output wen, selRd, selRa, selRb, rd,
    input  ra, rb
  );

  // Register-file side: accepts writes, returns read data.
  modport slave (
    input  wen, selRd, selRa, selRb, rd,
    output ra, rb
  );

endinterface : reg_file_if

// File: rtl/reg_file.sv
// Multi-ported register file: 2**ADDR_W x DATA_W storage, one synchronous
// write port, two combinational read ports, synchronous active-high clear.
module reg_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_if.slave   bus
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next-state storage: hold everything, load the selected entry on a write.
  always_comb begin
    regs_d = regs_q;
    if (bus.wen) begin
      regs_d[bus.selRd] = bus.rd;
    end
  end

  // Storage update; reset clears every entry and suppresses any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports are pure muxes off the stored state, so a write only becomes
  // visible after the edge that commits it.
  assign bus.ra = regs_q[bus.selRa];
  assign bus.rb = regs_q[bus.selRb];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed sequences, a vector table and a
// randomized run against an array-based reference model.
module tb_reg_file;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  logic [DATA_W-1:0] model [NREGS];

  typedef struct {
    logic              wen;
    logic [ADDR_W-1:0] sel_wr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] sel_a;
    logic [ADDR_W-1:0] sel_b;
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge with the current inputs; keeps the reference model in step.
  task automatic step();
    tick();
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
    end else if (bus.wen) begin
      model[bus.selRd] = bus.rd;
    end
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] sa,
                            input logic [ADDR_W-1:0] sb,
                            input logic [DATA_W-1:0] ea,
                            input logic [DATA_W-1:0] eb);
    bus.selRa = sa;
    bus.selRb = sb;
    #1;
    check({name, "_ra"}, bus.ra, ea);
    check({name, "_rb"}, bus.rb, eb);
  endtask

  initial begin
    bus.wen   = 1'b0;
    bus.selRd = '0;
    bus.selRa = '0;
    bus.selRb = '0;
    bus.rd    = '0;
    for (int i = 0; i < int'(NREGS); i++) model[i] = '0;

    // Reset beats a concurrent all-ones write.
    rst       = 1'b1;
    bus.wen   = 1'b1;
    bus.rd    = 16'hFFFF;
    bus.selRd = 4'd3;
    step();
    bus.selRd = 4'd0;
    step();
    rst     = 1'b0;
    bus.wen = 1'b0;
    for (int k = 0; k < int'(NREGS); k++)
      read_check("reset_read", ADDR_W'(k), ADDR_W'(NREGS - 1 - k), '0, '0);

    // Sweep: each register gets its own index.
    for (int i = 0; i < int'(NREGS); i++) begin
      bus.wen   = 1'b1;
      bus.selRd = ADDR_W'(i);
      bus.selRa = ADDR_W'(i);
      bus.selRb = ADDR_W'(i);
      bus.rd    = DATA_W'(i);
      step();
      check("sweep_ra", bus.ra, DATA_W'(i));
      check("sweep_rb", bus.rb, DATA_W'(i));
    end
    bus.wen = 1'b0;
    for (int k = 0; k < int'(NREGS); k++)
      read_check("sweep_read", ADDR_W'(k), ADDR_W'(k), DATA_W'(k), DATA_W'(k));

    // Write disabled: register 5 keeps its value.
    bus.wen   = 1'b0;
    bus.selRd = 4'd5;
    bus.rd    = 16'hBEEF;
    step();
    read_check("wen_low", 4'd5, 4'd5, 16'd5, 16'd5);

    // Independent and coincident read selects.
    read_check("dual_read", 4'd3, 4'd12, 16'd3, 16'd12);
    read_check("same_read", 4'd7, 4'd7, 16'd7, 16'd7);

    // No write-through: old value before the edge, new value after.
    bus.wen   = 1'b1;
    bus.selRd = 4'd9;
    bus.rd    = 16'h1234;
    read_check("pre_edge", 4'd9, 4'd9, 16'd9, 16'd9);
    step();
    check("post_edge_ra", bus.ra, 16'h1234);
    check("post_edge_rb", bus.rb, 16'h1234);
    bus.wen = 1'b0;

    // Reset pulse between edges leaves contents untouched.
    rst = 1'b1;
    #1;
    check("async_rst_ra", bus.ra, 16'h1234);
    rst = 1'b0;
    #1;
    read_check("async_rst_after", 4'd9, 4'd4, 16'h1234, 16'd4);

    // Table of single-edge write/read vectors, applied in order.
    vecs[0] = '{1'b1, 4'd2,  16'hFFFF, 4'd2,  4'd3,  16'hFFFF, 16'h0003};
    vecs[1] = '{1'b0, 4'd2,  16'h0000, 4'd2,  4'd2,  16'hFFFF, 16'hFFFF};
    vecs[2] = '{1'b1, 4'd0,  16'h8000, 4'd0,  4'd1,  16'h8000, 16'h0001};
    vecs[3] = '{1'b1, 4'd1,  16'h7FFF, 4'd0,  4'd1,  16'h8000, 16'h7FFF};
    vecs[4] = '{1'b0, 4'd5,  16'hBEEF, 4'd5,  4'd4,  16'h0005, 16'h0004};
    vecs[5] = '{1'b1, 4'd15, 16'h0001, 4'd15, 4'd14, 16'h0001, 16'h000E};
    for (int v = 0; v < 6; v++) begin
      bus.wen   = vecs[v].wen;
      bus.selRd = vecs[v].sel_wr;
      bus.rd    = vecs[v].wdata;
      bus.selRa = vecs[v].sel_a;
      bus.selRb = vecs[v].sel_b;
      step();
      check($sformatf("vec%0d_ra", v), bus.ra, vecs[v].exp_a);
      check($sformatf("vec%0d_rb", v), bus.rb, vecs[v].exp_b);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 29) == 0);
      bus.wen   = 1'($urandom_range(0, 1));
      bus.selRd = ADDR_W'($urandom_range(0, NREGS - 1));
      bus.rd    = DATA_W'($urandom);
      bus.selRa = ($urandom_range(0, 3) == 0) ? bus.selRd
                                              : ADDR_W'($urandom_range(0, NREGS - 1));
      bus.selRb = ADDR_W'($urandom_range(0, NREGS - 1));
      #1;
      check("rand_pre_ra", bus.ra, model[bus.selRa]);
      step();
      check("rand_post_ra", bus.ra, model[bus.selRa]);
      check("rand_post_rb", bus.rb, model[bus.selRb]);
    end
    rst     = 1'b0;
    bus.wen = 1'b0;

    // Top register written, then a single reset edge clears everything.
    bus.wen   = 1'b1;
    bus.selRd = 4'd15;
    bus.rd    = 16'hA5A5;
    step();
    read_check("top_write", 4'd15, 4'd15, 16'hA5A5, 16'hA5A5);
    bus.wen = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < int'(NREGS); k++)
      read_check("final_reset", ADDR_W'(k), ADDR_W'(k), '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_file
